// File: rtl/simd_booth_sequencer.sv
// simd_booth_sequencer
// Sequencing controller for the SIMD radix-2 Booth multiplier. Owns the packed
// 36-bit Z accumulator. Per-lane Booth commands are decoded from Z, and the
// shifter result is clocked back for 16, 8 or 4 iterations. The packed signed
// product is then presented with a one-cycle done pulse.

module simd_booth_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic [15:0] multiplicand,
    input  logic [15:0] multiplier,
    input  logic [35:0] shift_in,
    output logic [35:0] z_q,
    output logic [1:0]  mode_q,
    output logic [15:0] a_field,
    output logic [15:0] m_field,
    output logic [7:0]  lane_op,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] product
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_1X16 = 2'b00;
    localparam logic [1:0] MODE_2X8  = 2'b01;
    localparam logic [1:0] MODE_4X4  = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic        accept;
    logic        reject;
    logic        last_iter;
    logic [35:0] z_load;
    logic [3:0]  cnt_load;
    logic [31:0] product_next;

    // Booth recoding of one lane from its {Q lsb, q-1} pair
    function automatic logic [1:0] booth_op(input logic [1:0] pair);
        case (pair)
            2'b01:   booth_op = OP_ADD;
            2'b10:   booth_op = OP_SUB;
            default: booth_op = OP_NONE;
        endcase
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept or reject a request in IDLE/DONE, count out ITER
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        reject     = 1'b0;
        last_iter  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start && (mode != MODE_RSVD)) begin
                    accept     = 1'b1;
                    state_next = ITER;
                end else begin
                    reject     = start;
                    state_next = IDLE;
                end
            end
            ITER: begin
                if (cnt == 4'd0) begin
                    last_iter  = 1'b1;
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Initial Z image for a new request: multiplier in the Q fields, A and q-1 cleared
    always_comb begin
        z_load   = '0;
        cnt_load = 4'd0;
        case (mode)
            MODE_1X16: begin
                z_load[16:1] = multiplier;
                cnt_load     = 4'd15;
            end
            MODE_2X8: begin
                z_load[25:18] = multiplier[15:8];
                z_load[8:1]   = multiplier[7:0];
                cnt_load      = 4'd7;
            end
            MODE_4X4: begin
                for (int k = 0; k < 4; k++) begin
                    z_load[9*k+1 +: 4] = multiplier[4*k +: 4];
                end
                cnt_load = 4'd3;
            end
            default: begin
                z_load   = '0;
                cnt_load = 4'd0;
            end
        endcase
    end

    // Adder-facing views of Z: packed A fields and per-lane add/sub/none commands
    always_comb begin
        a_field = '0;
        lane_op = '0;
        case (mode_q)
            MODE_1X16: begin
                a_field = z_q[32:17];
                if (state == ITER) begin
                    lane_op[1:0] = booth_op(z_q[1:0]);
                end
            end
            MODE_2X8: begin
                a_field = {z_q[33:26], z_q[16:9]};
                if (state == ITER) begin
                    lane_op[1:0] = booth_op(z_q[1:0]);
                    lane_op[3:2] = booth_op(z_q[18:17]);
                end
            end
            MODE_4X4: begin
                for (int k = 0; k < 4; k++) begin
                    a_field[4*k +: 4] = z_q[9*k+5 +: 4];
                    if (state == ITER) begin
                        lane_op[2*k +: 2] = booth_op(z_q[9*k +: 2]);
                    end
                end
            end
            default: begin
                a_field = '0;
                lane_op = '0;
            end
        endcase
    end

    // Packed {A,Q} per lane taken from the final shifter output
    always_comb begin
        product_next = '0;
        case (mode_q)
            MODE_1X16: product_next = shift_in[32:1];
            MODE_2X8:  product_next = {shift_in[33:18], shift_in[16:1]};
            MODE_4X4: begin
                for (int k = 0; k < 4; k++) begin
                    product_next[8*k +: 8] = shift_in[9*k+1 +: 8];
                end
            end
            default: product_next = '0;
        endcase
    end

    // Datapath registers: load on accept, shift during ITER, capture product on the last shift
    always_ff @(posedge clk) begin
        if (rst) begin
            z_q     <= '0;
            m_field <= '0;
            mode_q  <= '0;
            cnt     <= '0;
            product <= '0;
            err     <= 1'b0;
        end else begin
            err <= reject;
            if (accept) begin
                z_q     <= z_load;
                m_field <= multiplicand;
                mode_q  <= mode;
                cnt     <= cnt_load;
            end else if (state == ITER) begin
                z_q <= shift_in;
                cnt <= cnt - 4'd1;
                if (last_iter) begin
                    product <= product_next;
                end
            end
        end
    end

    assign busy = (state == ITER);
    assign done = (state == DONE);

endmodule

// File: tb/tb_simd_booth_sequencer.sv
// Testbench for simd_booth_sequencer. Models the lane-split adder and the
// arithmetic shifter around the controller, and keeps a scoreboard of
// expected products and done cycles.

module tb_simd_booth_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [15:0] multiplicand = '0;
    logic [15:0] multiplier = '0;
    logic [35:0] shift_in;
    logic [35:0] z_q;
    logic [1:0]  mode_q;
    logic [15:0] a_field;
    logic [15:0] m_field;
    logic [7:0]  lane_op;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] product;

    logic [35:0] garbage = '0;
    logic        use_garbage = 1'b1;
    logic [16:0] s_tmp;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] product;
        int          done_cyc;
    } exp_t;

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] m;
        logic [15:0] q;
        logic [31:0] exp;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[8];

    simd_booth_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .mode         (mode),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .shift_in     (shift_in),
        .z_q          (z_q),
        .mode_q       (mode_q),
        .a_field      (a_field),
        .m_field      (m_field),
        .lane_op      (lane_op),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .product      (product)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Edge counter used to time-stamp accepts and done pulses
    always @(posedge clk) cyc <= cyc + 1;

    // Sign-extend a lane of width w to 17 bits and apply the Booth command
    function automatic logic [16:0] lane_sum(input logic [15:0] a, input logic [15:0] m,
                                             input logic [1:0] op, input int w);
        logic [16:0] ae;
        logic [16:0] me;
        ae = '0;
        me = '0;
        for (int i = 0; i < 16; i++) begin
            ae[i] = (i < w) ? a[i] : a[w-1];
            me[i] = (i < w) ? m[i] : m[w-1];
        end
        ae[16] = a[w-1];
        me[16] = m[w-1];
        case (op)
            2'b01:   lane_sum = ae + me;
            2'b10:   lane_sum = ae - me;
            default: lane_sum = ae;
        endcase
    endfunction

    // Adder + arithmetic shifter model: new lane field = {w+1-bit sum, old Q}
    always_comb begin
        shift_in = '0;
        s_tmp    = '0;
        if (use_garbage) begin
            shift_in = garbage;
        end else begin
            case (mode_q)
                2'b00: begin
                    s_tmp = lane_sum(a_field, m_field, lane_op[1:0], 16);
                    shift_in[32:0] = {s_tmp, z_q[16:1]};
                end
                2'b01: begin
                    s_tmp = lane_sum({8'h00, a_field[15:8]}, {8'h00, m_field[15:8]}, lane_op[3:2], 8);
                    shift_in[33:17] = {s_tmp[8:0], z_q[25:18]};
                    s_tmp = lane_sum({8'h00, a_field[7:0]}, {8'h00, m_field[7:0]}, lane_op[1:0], 8);
                    shift_in[16:0] = {s_tmp[8:0], z_q[8:1]};
                end
                2'b10: begin
                    for (int k = 0; k < 4; k++) begin
                        s_tmp = lane_sum({12'h000, a_field[4*k +: 4]}, {12'h000, m_field[4*k +: 4]},
                                         lane_op[2*k +: 2], 4);
                        shift_in[9*k +: 9] = {s_tmp[4:0], z_q[9*k+1 +: 4]};
                    end
                end
                default: shift_in = '0;
            endcase
        end
    end

    // Reference packed signed product, lane by lane
    function automatic logic [31:0] ref_product(input logic [1:0] md, input logic [15:0] m,
                                                input logic [15:0] q);
        logic [31:0] r;
        int a;
        int b;
        r = '0;
        case (md)
            2'b00: begin
                a = $signed(m);
                b = $signed(q);
                r = 32'(a * b);
            end
            2'b01: begin
                for (int l = 0; l < 2; l++) begin
                    a = $signed(m[8*l +: 8]);
                    b = $signed(q[8*l +: 8]);
                    r[16*l +: 16] = 16'(a * b);
                end
            end
            2'b10: begin
                for (int l = 0; l < 4; l++) begin
                    a = $signed(m[4*l +: 4]);
                    b = $signed(q[4*l +: 4]);
                    r[8*l +: 8] = 8'(a * b);
                end
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Expected Z image right after accept
    function automatic logic [35:0] exp_z(input logic [1:0] md, input logic [15:0] q);
        logic [35:0] z;
        z = '0;
        case (md)
            2'b00: z[16:1] = q;
            2'b01: begin
                z[25:18] = q[15:8];
                z[8:1]   = q[7:0];
            end
            2'b10: begin
                for (int k = 0; k < 4; k++) z[9*k+1 +: 4] = q[4*k +: 4];
            end
            default: z = '0;
        endcase
        return z;
    endfunction

    // Expected first-iteration commands: q-1 = 0, so a lane subtracts iff its Q lsb is 1
    function automatic logic [7:0] exp_first_op(input logic [1:0] md, input logic [15:0] q);
        logic [7:0] op;
        int nl;
        int w;
        op = '0;
        nl = (md == 2'b00) ? 1 : (md == 2'b01) ? 2 : 4;
        w  = 16 / nl;
        for (int l = 0; l < nl; l++) op[2*l +: 2] = q[w*l] ? 2'b10 : 2'b00;
        return op;
    endfunction

    task automatic checkOutput(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every done pulse pops one expected product and done cycle
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("product", product, mon_e.product);
                checkOutput("done_cycle", cyc, mon_e.done_cyc);
            end
        end
    end

    task automatic waitDone(input int limit, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        checkOutput({tag, "_done_seen"}, seen, 1'b1);
    endtask

    // Single request: drive, push the expectation, check the load image, count busy cycles
    task automatic applyStimulus(input logic [1:0] md, input logic [15:0] m, input logic [15:0] q,
                                 input logic [31:0] exp, input string tag);
        int   n;
        int   busy_cnt;
        bit   seen;
        exp_t e;
        n = (md == 2'b00) ? 16 : (md == 2'b01) ? 8 : 4;
        @(negedge clk);
        mode         = md;
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        e.product    = exp;
        e.done_cyc   = cyc + 1 + n;
        sb.push_back(e);
        @(negedge clk);
        start        = 1'b0;
        multiplicand = 16'($urandom);
        multiplier   = 16'($urandom);
        mode         = 2'($urandom);
        checkOutput({tag, "_z_load"}, z_q, exp_z(md, q));
        checkOutput({tag, "_a_field"}, a_field, 36'h0);
        checkOutput({tag, "_m_field"}, m_field, m);
        checkOutput({tag, "_mode_q"}, mode_q, md);
        checkOutput({tag, "_lane_op"}, lane_op, exp_first_op(md, q));
        busy_cnt = 0;
        seen     = 1'b0;
        for (int i = 0; i < n + 4 && !seen; i++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (busy === 1'b1) busy_cnt++;
                @(negedge clk);
            end
        end
        checkOutput({tag, "_done_seen"}, seen, 1'b1);
        checkOutput({tag, "_busy_cycles"}, busy_cnt, n);
        checkOutput({tag, "_busy_at_done"}, busy, 1'b0);
        checkOutput({tag, "_lane_op_at_done"}, lane_op, 36'h0);
    endtask

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence
    initial begin
        exp_t e;
        int   t0;
        int   limit;

        vecs[0] = '{2'b00, 16'h0003, 16'hFFFB, 32'hFFFFFFF1};
        vecs[1] = '{2'b01, 16'h8007, 16'h80FD, 32'h4000FFEB};
        vecs[2] = '{2'b10, 16'h7880, 16'h7875, 32'h3140C800};
        vecs[3] = '{2'b00, 16'h7FFF, 16'h8001, ref_product(2'b00, 16'h7FFF, 16'h8001)};
        vecs[4] = '{2'b10, 16'h8888, 16'h8888, 32'h40404040};
        vecs[5] = '{2'b01, 16'h7F80, 16'h807F, ref_product(2'b01, 16'h7F80, 16'h807F)};
        vecs[6] = '{2'b00, 16'h8000, 16'h7FFF, ref_product(2'b00, 16'h8000, 16'h7FFF)};
        vecs[7] = '{2'b10, 16'h1F9A, 16'hE7C3, ref_product(2'b10, 16'h1F9A, 16'hE7C3)};

        // Reset with random inputs
        rst = 1'b1;
        use_garbage = 1'b1;
        repeat (3) begin
            @(negedge clk);
            start        = 1'($urandom);
            mode         = 2'($urandom);
            multiplicand = 16'($urandom);
            multiplier   = 16'($urandom);
            garbage      = {4'($urandom), 32'($urandom)};
        end
        @(negedge clk);
        checkOutput("rst_z_q", z_q, 36'h0);
        checkOutput("rst_mode_q", mode_q, 36'h0);
        checkOutput("rst_a_field", a_field, 36'h0);
        checkOutput("rst_m_field", m_field, 36'h0);
        checkOutput("rst_lane_op", lane_op, 36'h0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_err", err, 1'b0);
        checkOutput("rst_product", product, 36'h0);

        // Idle with garbage on shift_in: Z must not move
        rst   = 1'b0;
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            garbage = {4'($urandom), 32'($urandom)};
        end
        checkOutput("idle_z_q", z_q, 36'h0);
        checkOutput("idle_busy", busy, 1'b0);

        // Reserved mode: err pulse only
        start        = 1'b1;
        mode         = 2'b11;
        multiplicand = 16'h1234;
        multiplier   = 16'h5678;
        @(negedge clk);
        start = 1'b0;
        checkOutput("err_pulse", err, 1'b1);
        checkOutput("err_busy", busy, 1'b0);
        checkOutput("err_m_field", m_field, 36'h0);
        checkOutput("err_z_q", z_q, 36'h0);
        @(negedge clk);
        checkOutput("err_clear", err, 1'b0);
        checkOutput("err_no_busy", busy, 1'b0);

        // Table of single requests
        use_garbage = 1'b0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].mode, vecs[i].m, vecs[i].q, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // start pulsed mid-ITER must be ignored
        @(negedge clk);
        mode = 2'b01; multiplicand = 16'h1234; multiplier = 16'hF00D; start = 1'b1;
        e.product  = ref_product(2'b01, 16'h1234, 16'hF00D);
        e.done_cyc = cyc + 1 + 8;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        mode = 2'b00; multiplicand = 16'hAAAA; multiplier = 16'h5555; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("mid_mode_q", mode_q, 2'b01);
        checkOutput("mid_m_field", m_field, 16'h1234);
        checkOutput("mid_busy", busy, 1'b1);
        waitDone(10, "mid");

        // Back-to-back: start held through done with a new operand pair
        @(negedge clk);
        mode = 2'b10; multiplicand = 16'h7880; multiplier = 16'h7875; start = 1'b1;
        t0 = cyc + 1;
        e.product  = 32'h3140C800;
        e.done_cyc = t0 + 4;
        sb.push_back(e);
        @(negedge clk);
        mode = 2'b01; multiplicand = 16'h8007; multiplier = 16'h80FD;
        limit = 0;
        while (done !== 1'b1 && limit < 10) begin
            @(negedge clk);
            limit++;
        end
        checkOutput("b2b_first_done", done, 1'b1);
        e.product  = 32'h4000FFEB;
        e.done_cyc = cyc + 1 + 8;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        checkOutput("b2b_busy_no_gap", busy, 1'b1);
        checkOutput("b2b_done_clear", done, 1'b0);
        checkOutput("b2b_mode_q", mode_q, 2'b01);
        waitDone(12, "b2b_second");

        // Abort by reset at iteration 5 of a 1x16 run
        @(negedge clk);
        mode = 2'b00; multiplicand = 16'h1357; multiplier = 16'h2468; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_done", done, 1'b0);
        checkOutput("abort_product", product, 36'h0);
        checkOutput("abort_z_q", z_q, 36'h0);
        checkOutput("abort_m_field", m_field, 36'h0);
        limit = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) limit++;
        end
        checkOutput("abort_no_done", limit, 0);
        applyStimulus(2'b00, 16'h8000, 16'h8000, 32'h40000000, "after_abort");

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
